// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter: opcode encodings, the decoded
// per-request control word and the stage/level partitioning helpers.
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    // Decoded once at entry; every level downstream only sees right shifts.
    typedef struct packed {
        logic left;
        logic rotate;
        logic fill;
        logic illegal;
    } ctrl_t;

    function automatic int levels_per_stage(input int size, input int stages);
        int levels;
        levels = $clog2(size);
        return (levels + stages - 1) / stages;
    endfunction

    function automatic int stage_levels(input int size, input int stages, input int s);
        int levels;
        int lps;
        int first;
        levels = $clog2(size);
        lps    = levels_per_stage(size, stages);
        first  = lps * s;
        if (first >= levels) return 0;
        return (levels - first < lps) ? levels - first : lps;
    endfunction

    function automatic ctrl_t decode(input logic [2:0] sel, input logic msb);
        ctrl_t c;
        c = '0;
        case (sel)
            OP_SLL:  c.left = 1'b1;
            OP_SRL:  c.fill = 1'b0;
            OP_SRA:  c.fill = msb;
            OP_ROR:  c.rotate = 1'b1;
            OP_ROL:  begin c.left = 1'b1; c.rotate = 1'b1; end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response bundle of the pipelined shifter.
interface pipelined_shifter_if #(
    parameter int size  = 32,
    parameter int TAG_W = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              Sel;
    logic [$clog2(size)-1:0] shamt;
    logic [size-1:0]         Data_in;
    logic [TAG_W-1:0]        tag_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [size-1:0]         Data_out;
    logic [TAG_W-1:0]        tag_out;
    logic                    illegal_op;

    // valid/ready: a transfer happens on a rising clk edge where both are 1;
    // a producer keeps valid and its payload stable until that edge.
    modport master (
        output in_valid, Sel, shamt, Data_in, tag_in, out_ready,
        input  in_ready, out_valid, Data_out, tag_out, illegal_op
    );
    modport slave (
        input  in_valid, Sel, shamt, Data_in, tag_in, out_ready,
        output in_ready, out_valid, Data_out, tag_out, illegal_op
    );
endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: a chain of COUNT right-shift levels starting at level
// FIRST, followed by a handshake register that collapses bubbles.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int FIRST = 0,
    parameter int COUNT = 1,
    parameter int size  = 32,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [size-1:0]         up_data,
    input  logic [$clog2(size)-1:0] up_shamt,
    input  ctrl_t                   up_ctrl,
    input  logic [TAG_W-1:0]        up_tag,
    output logic                    dn_valid,
    input  logic                    dn_ready,
    output logic [size-1:0]         dn_data,
    output logic [$clog2(size)-1:0] dn_shamt,
    output ctrl_t                   dn_ctrl,
    output logic [TAG_W-1:0]        dn_tag
);
    logic [size-1:0] lvl [COUNT+1];

    assign lvl[0] = up_data;

    for (genvar i = 0; i < COUNT; i++) begin : g_level
        localparam int AMT = 1 << (FIRST + i);
        logic [size-1:0] moved;
        assign moved  = up_ctrl.rotate ? {lvl[i][AMT-1:0], lvl[i][size-1:AMT]}
                                       : {{AMT{up_ctrl.fill}}, lvl[i][size-1:AMT]};
        assign lvl[i+1] = up_shamt[FIRST+i] ? moved : lvl[i];
    end

    // An empty stage accepts even while the stage after it is stalled.
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_shamt <= '0;
            dn_ctrl  <= '0;
            dn_tag   <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            dn_data  <= lvl[COUNT];
            dn_shamt <= up_shamt;
            dn_ctrl  <= up_ctrl;
            dn_tag   <= up_tag;
        end
    end
endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined logical/arithmetic shifter and rotator; left operations are
// bit-reversed at entry and exit so every level is a right shift.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int size   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_shifter_if.slave bus
);
    localparam int SW  = $clog2(size);
    localparam int LPS = levels_per_stage(size, STAGES);

    logic [STAGES:0]   valid;
    logic [STAGES:0]   ready;
    logic [size-1:0]   data [STAGES+1];
    logic [SW-1:0]     amt  [STAGES+1];
    ctrl_t             ctrl [STAGES+1];
    logic [TAG_W-1:0]  tag  [STAGES+1];
    logic [size-1:0]   din_rev;
    logic [size-1:0]   dout_rev;
    logic              unused_tail;

    assign din_rev  = {<<{bus.Data_in}};
    assign ctrl[0]  = decode(bus.Sel, bus.Data_in[size-1]);
    assign valid[0] = bus.in_valid;
    assign data[0]  = ctrl[0].left ? din_rev : bus.Data_in;
    // Reserved opcodes travel with a zero amount so they pass through untouched.
    assign amt[0]   = ctrl[0].illegal ? '0 : bus.shamt;
    assign tag[0]   = bus.tag_in;

    assign bus.in_ready  = ready[0];
    assign ready[STAGES] = bus.out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .FIRST (LPS * s),
            .COUNT (stage_levels(size, STAGES, s)),
            .size  (size),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (valid[s]),
            .up_ready (ready[s]),
            .up_data  (data[s]),
            .up_shamt (amt[s]),
            .up_ctrl  (ctrl[s]),
            .up_tag   (tag[s]),
            .dn_valid (valid[s+1]),
            .dn_ready (ready[s+1]),
            .dn_data  (data[s+1]),
            .dn_shamt (amt[s+1]),
            .dn_ctrl  (ctrl[s+1]),
            .dn_tag   (tag[s+1])
        );
    end

    assign dout_rev       = {<<{data[STAGES]}};
    assign bus.out_valid  = valid[STAGES];
    assign bus.Data_out   = ctrl[STAGES].left ? dout_rev : data[STAGES];
    assign bus.tag_out    = tag[STAGES];
    assign bus.illegal_op = ctrl[STAGES].illegal;

    assign unused_tail = ^{amt[STAGES], ctrl[STAGES].rotate, ctrl[STAGES].fill};
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed scenarios, a randomized
// backpressured stream against a queue-based reference, and a parameter sweep.
module tb_pipelined_shifter;
    localparam int EW = 1 + 5 + 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;
    logic [EW-1:0] exp_q[$];

    pipelined_shifter_if #(.size(32), .TAG_W(5)) bus ();
    pipelined_shifter_if #(.size(32), .TAG_W(5)) bus1 ();
    pipelined_shifter_if #(.size(32), .TAG_W(5)) bus5 ();
    pipelined_shifter_if #(.size(8),  .TAG_W(5)) bus8 ();

    pipelined_shifter #(.size(32), .STAGES(2), .TAG_W(5)) dut  (.clk(clk), .reset(reset), .bus(bus));
    pipelined_shifter #(.size(32), .STAGES(1), .TAG_W(5)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pipelined_shifter #(.size(32), .STAGES(5), .TAG_W(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
    pipelined_shifter #(.size(8),  .STAGES(3), .TAG_W(5)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [2:0] sel, input int n,
                                          input logic [31:0] d, input int w);
        logic [63:0] x, mask, r;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        case (sel)
            3'b000:  r = x << n;
            3'b010:  r = x >> n;
            3'b001:  r = (((x >> (w - 1)) & 64'd1) != 0) ? ((x >> n) | (mask << (w - n))) : (x >> n);
            3'b011:  r = (x >> n) | (x << (w - n));
            3'b100:  r = (x << n) | (x >> (w - n));
            default: r = x;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [2:0] sel, input logic [4:0] sh,
                         input logic [31:0] d, input logic [4:0] tg);
        bus.in_valid = v;
        bus.Sel      = sel;
        bus.shamt    = sh;
        bus.Data_in  = d;
        bus.tag_in   = tg;
    endtask

    // Lets combinational outputs settle, then records accepted requests.
    task automatic settle();
        #1;
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back({(bus.Sel > 3'd4), bus.tag_in, model(bus.Sel, int'(bus.shamt), bus.Data_in, 32)});
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            drive(1'b0, 3'd0, 5'd0, 32'd0, 5'd0);
            settle();
            n++;
        end while (!bus.out_valid && n < 10);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.Data_out !== 32'd0) $display("FAIL reset_data: got %h want 0", bus.Data_out); else passed++;
        checks++; if (bus.tag_out !== 5'd0) $display("FAIL reset_tag: got %h want 0", bus.tag_out); else passed++;
        checks++; if (bus.illegal_op !== 1'b0) $display("FAIL reset_illegal: got %b want 0", bus.illegal_op); else passed++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_sra_ones();
        int n;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b001, 5'd31, 32'h8000_0000, 5'd7);
        settle();
        wait_out(n);
        checks++; if (n !== 2) $display("FAIL sra_latency: got %0d want 2", n); else passed++;
        checks++; if (bus.Data_out !== 32'hFFFF_FFFF) $display("FAIL sra_data: got %h want ffffffff", bus.Data_out); else passed++;
        checks++; if (bus.tag_out !== 5'd7) $display("FAIL sra_tag: got %h want 07", bus.tag_out); else passed++;
        checks++; if (bus.illegal_op !== 1'b0) $display("FAIL sra_illegal: got %b want 0", bus.illegal_op); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        drive(1'b1, 3'b011, 5'd1, 32'h0000_0001, 5'd1);
        settle();
        @(negedge clk);
        drive(1'b1, 3'b100, 5'd4, 32'h8000_0000, 5'd2);
        settle();
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_accept: got %b want 1", bus.in_ready); else passed++;
        wait_out(n);
        checks++; if (bus.Data_out !== 32'h8000_0000) $display("FAIL b2b_ror: got %h want 80000000", bus.Data_out); else passed++;
        checks++; if (bus.tag_out !== 5'd1) $display("FAIL b2b_tag1: got %h want 01", bus.tag_out); else passed++;
        @(negedge clk);
        drive(1'b0, 3'd0, 5'd0, 32'd0, 5'd0);
        settle();
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_consecutive: got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.Data_out !== 32'h0000_0008) $display("FAIL b2b_rol: got %h want 00000008", bus.Data_out); else passed++;
        checks++; if (bus.tag_out !== 5'd2) $display("FAIL b2b_tag2: got %h want 02", bus.tag_out); else passed++;
    endtask

    task automatic test_stream();
        int sent, got, inflight, cyc;
        logic pending, stalled_prev, acc, emit;
        logic [EW-1:0] prev_out, exp;
        sent = 0; got = 0; inflight = 0; cyc = 0;
        pending = 1'b0; stalled_prev = 1'b0; prev_out = '0;
        exp_q.delete();
        while ((sent < 10 || got < 10) && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = (cyc % 3 == 0);
            if (!pending && sent < 10) begin
                drive(1'b1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
                pending = 1'b1;
            end else if (!pending) begin
                drive(1'b0, 3'd0, 5'd0, 32'd0, 5'd0);
            end
            settle();
            if (stalled_prev) begin
                checks++;
                if (!bus.out_valid || {bus.illegal_op, bus.tag_out, bus.Data_out} !== prev_out)
                    $display("FAIL stream_stall_hold: got %b/%h want 1/%h", bus.out_valid,
                             {bus.illegal_op, bus.tag_out, bus.Data_out}, prev_out);
                else passed++;
            end
            checks++;
            if (bus.in_ready !== !(inflight == 2 && !bus.out_ready))
                $display("FAIL stream_in_ready: got %b want %b (in flight %0d)", bus.in_ready,
                         !(inflight == 2 && !bus.out_ready), inflight);
            else passed++;
            acc  = bus.in_valid && bus.in_ready;
            emit = bus.out_valid && bus.out_ready;
            if (emit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_unexpected: got %h want nothing", bus.Data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.illegal_op, bus.tag_out, bus.Data_out} !== exp)
                        $display("FAIL stream_result: got %h want %h", {bus.illegal_op, bus.tag_out, bus.Data_out}, exp);
                    else passed++;
                end
                got++;
            end
            if (acc) begin
                sent++;
                pending = 1'b0;
            end
            inflight = inflight + int'(acc) - int'(emit);
            stalled_prev = bus.out_valid && !bus.out_ready;
            prev_out = {bus.illegal_op, bus.tag_out, bus.Data_out};
            cyc++;
        end
        checks++; if (got !== 10) $display("FAIL stream_count: got %0d want 10", got); else passed++;
    endtask

    task automatic test_illegal();
        int n;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b110, 5'd5, 32'h1234_ABCD, 5'd3);
        settle();
        @(negedge clk);
        drive(1'b1, 3'b010, 5'd4, 32'h0000_00F0, 5'd4);
        settle();
        wait_out(n);
        checks++; if (bus.Data_out !== 32'h1234_ABCD) $display("FAIL illegal_data: got %h want 1234abcd", bus.Data_out); else passed++;
        checks++; if (bus.illegal_op !== 1'b1) $display("FAIL illegal_flag: got %b want 1", bus.illegal_op); else passed++;
        checks++; if (bus.tag_out !== 5'd3) $display("FAIL illegal_tag: got %h want 03", bus.tag_out); else passed++;
        @(negedge clk);
        drive(1'b0, 3'd0, 5'd0, 32'd0, 5'd0);
        settle();
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL legal_valid: got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.Data_out !== 32'h0000_000F) $display("FAIL legal_data: got %h want 0000000f", bus.Data_out); else passed++;
        checks++; if (bus.illegal_op !== 1'b0) $display("FAIL legal_flag: got %b want 0", bus.illegal_op); else passed++;
    endtask

    task automatic test_reset_flush();
        int n;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b011, 5'd3, $urandom, 5'd9);
        settle();
        @(negedge clk);
        drive(1'b1, 3'b000, 5'd2, $urandom, 5'd10);
        settle();
        @(negedge clk);
        drive(1'b0, 3'd0, 5'd0, 32'd0, 5'd0);
        settle();
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_preload: got %b want 1", bus.out_valid); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_async: got %b want 0", bus.out_valid); else passed++;
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            settle();
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_quiet: got %b want 0 (cycle %0d)", bus.out_valid, c); else passed++;
            checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1 (cycle %0d)", bus.in_ready, c); else passed++;
        end
        @(negedge clk);
        drive(1'b1, 3'b010, 5'd1, 32'h0000_0010, 5'd11);
        settle();
        wait_out(n);
        checks++; if (bus.Data_out !== 32'h0000_0008) $display("FAIL flush_resume: got %h want 00000008", bus.Data_out); else passed++;
        checks++; if (bus.tag_out !== 5'd11) $display("FAIL flush_resume_tag: got %h want 0b", bus.tag_out); else passed++;
        exp_q.delete();
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 4; v++) begin
            logic [2:0]  sel;
            int          sh, lat1, lat5, lat8;
            logic [31:0] d, got1, got5;
            logic [7:0]  got8;
            sel  = (v == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            sh   = (v == 0) ? 3 : int'($urandom_range(0, 7));
            d    = (v == 0) ? 32'h0000_00A5 : $urandom;
            lat1 = 0; lat5 = 0; lat8 = 0;
            got1 = '0; got5 = '0; got8 = '0;
            @(negedge clk);
            bus1.in_valid = 1'b1; bus1.Sel = sel; bus1.shamt = 5'(sh); bus1.Data_in = d;      bus1.tag_in = 5'(v);
            bus5.in_valid = 1'b1; bus5.Sel = sel; bus5.shamt = 5'(sh); bus5.Data_in = d;      bus5.tag_in = 5'(v);
            bus8.in_valid = 1'b1; bus8.Sel = sel; bus8.shamt = 3'(sh); bus8.Data_in = d[7:0]; bus8.tag_in = 5'(v);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                bus1.in_valid = 1'b0;
                bus5.in_valid = 1'b0;
                bus8.in_valid = 1'b0;
                #1;
                if (bus1.out_valid && lat1 == 0) begin lat1 = c; got1 = bus1.Data_out; end
                if (bus5.out_valid && lat5 == 0) begin lat5 = c; got5 = bus5.Data_out; end
                if (bus8.out_valid && lat8 == 0) begin lat8 = c; got8 = bus8.Data_out; end
            end
            checks++; if (lat1 !== 1) $display("FAIL sweep_s1_latency: got %0d want 1", lat1); else passed++;
            checks++; if (lat5 !== 5) $display("FAIL sweep_s5_latency: got %0d want 5", lat5); else passed++;
            checks++; if (lat8 !== 3) $display("FAIL sweep_w8_latency: got %0d want 3", lat8); else passed++;
            checks++; if (got1 !== model(sel, sh, d, 32)) $display("FAIL sweep_s1_data: got %h want %h", got1, model(sel, sh, d, 32)); else passed++;
            checks++; if (got5 !== model(sel, sh, d, 32)) $display("FAIL sweep_s5_data: got %h want %h", got5, model(sel, sh, d, 32)); else passed++;
            checks++; if ({24'd0, got8} !== model(sel, sh, d, 8)) $display("FAIL sweep_w8_data: got %h want %h", got8, model(sel, sh, d, 8)); else passed++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive(1'b0, 3'd0, 5'd0, 32'd0, 5'd0);
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0; bus1.Sel = 3'd0; bus1.shamt = '0; bus1.Data_in = '0; bus1.tag_in = '0; bus1.out_ready = 1'b1;
        bus5.in_valid  = 1'b0; bus5.Sel = 3'd0; bus5.shamt = '0; bus5.Data_in = '0; bus5.tag_in = '0; bus5.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.Sel = 3'd0; bus8.shamt = '0; bus8.Data_in = '0; bus8.tag_in = '0; bus8.out_ready = 1'b1;
        test_reset();
        test_sra_ones();
        test_back_to_back();
        test_stream();
        test_illegal();
        test_reset_flush();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
